// File: rtl/gate_stim_checker_pkg.sv
// Shared definitions for the gate stimulus/checker block and its sibling benches:
// FSM state encodings and truth tables for the common two-input gates.
package gate_stim_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit i of each table is the expected gate output when the input vector equals i.
    localparam logic [3:0] TT_AND2  = 4'b1000;
    localparam logic [3:0] TT_OR2   = 4'b1110;
    localparam logic [3:0] TT_XOR2  = 4'b0110;
    localparam logic [3:0] TT_NAND2 = 4'b0111;

endpackage

// File: rtl/gate_stim_checker_hold_timer.sv
// Counts the clocks for which a stimulus vector has been held.
// 'last' marks the final hold cycle; the counter wraps to 0 on the following edge.
module hold_timer #(
    parameter int HOLD_CYCLES = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic last
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0] count_q;

    assign last = (count_q == LAST_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= last ? '0 : count_q + CW'(1);
        end
    end

endmodule

// File: rtl/gate_stim_checker.sv
// Self-running stimulus sequencer and response checker for small combinational gates.
// Walks every input vector in ascending order and checks dut_y against a truth table.
module gate_stim_checker
    import gate_stim_checker_pkg::*;
#(
    parameter int                       N_IN        = 2,
    parameter int                       HOLD_CYCLES = 10,
    parameter logic [(1<<N_IN)-1:0]     EXPECTED    = TT_AND2,
    parameter int                       ERR_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              dut_y,
    output logic [N_IN-1:0]   stim,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [N_IN-1:0]   first_err_vec
);

    if (HOLD_CYCLES < 2 || N_IN < 1 || N_IN > 6) begin : g_param_check
        $error("gate_stim_checker: illegal parameters N_IN=%0d HOLD_CYCLES=%0d", N_IN, HOLD_CYCLES);
    end

    localparam logic [N_IN-1:0]  LAST_VEC = '1;
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   stim_q;
    logic [ERR_W-1:0]  err_count_q;
    logic [ERR_W-1:0]  err_next;
    logic [N_IN-1:0]   first_err_q;
    logic              err_seen_q;
    logic              pass_q;
    logic              hold_last;
    logic              start_run;
    logic              sample;
    logic              finish;
    logic              mismatch;

    hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (start_run),
        .en    (state_q == ST_RUN),
        .last  (hold_last)
    );

    // Case inequality so an X or Z on the DUT output is always reported as a mismatch.
    assign mismatch = (dut_y !== EXPECTED[stim_q]);
    assign err_next = (mismatch && err_count_q != ERR_MAX) ? err_count_q + ERR_W'(1) : err_count_q;

    always_comb begin
        state_d   = state_q;
        start_run = 1'b0;
        sample    = 1'b0;
        finish    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    start_run = 1'b1;
                end
            end
            ST_RUN: begin
                if (hold_last) begin
                    sample = 1'b1;
                    if (stim_q == LAST_VEC) begin
                        finish  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stim_q      <= '0;
            err_count_q <= '0;
            first_err_q <= '0;
            err_seen_q  <= 1'b0;
            pass_q      <= 1'b0;
        end else if (start_run) begin
            stim_q      <= '0;
            err_count_q <= '0;
            first_err_q <= '0;
            err_seen_q  <= 1'b0;
            pass_q      <= 1'b0;
        end else if (sample) begin
            err_count_q <= err_next;
            if (mismatch && !err_seen_q) begin
                first_err_q <= stim_q;
                err_seen_q  <= 1'b1;
            end
            // The final vector stays on stim so the DUT output remains observable in DONE.
            if (finish) begin
                pass_q <= (err_next == '0);
            end else begin
                stim_q <= stim_q + N_IN'(1);
            end
        end
    end

    assign stim          = stim_q;
    assign busy          = (state_q == ST_RUN);
    assign done          = (state_q == ST_DONE);
    assign pass          = pass_q;
    assign err_count     = err_count_q;
    assign first_err_vec = first_err_q;

endmodule

// File: tb/tb_gate_stim_checker.sv
// Directed bench for gate_stim_checker: a default-size instance driven by a selectable gate
// model, plus two boundary instances (N_IN=3, HOLD_CYCLES=2, ERR_W=2).
module tb_gate_stim_checker;
    import gate_stim_checker_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic start0;
    logic start1;
    int   mode;
    int   checks = 0;
    int   errors = 0;
    logic [1:0] stim_seen [4];

    logic [1:0] stim0, first0;
    logic [7:0] err0;
    logic       y0, busy0, done0, pass0;

    logic [2:0] stim_s, first_s, stim_x, first_x;
    logic [1:0] err_s, err_x;
    logic       busy_s, done_s, pass_s, busy_x, done_x, pass_x;
    logic       y_s, y_x;

    always #5 clk = ~clk;

    // Gate model: 0 = correct AND, 1 = stuck-at-0, 2 = NAND.
    always_comb begin
        case (mode)
            1:       y0 = 1'b0;
            2:       y0 = ~(stim0[0] & stim0[1]);
            default: y0 = stim0[0] & stim0[1];
        endcase
    end

    assign y_s = 1'b1;
    assign y_x = 1'bx;

    gate_stim_checker #(
        .N_IN(2), .HOLD_CYCLES(10), .EXPECTED(TT_AND2), .ERR_W(8)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start0), .dut_y(y0), .stim(stim0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .first_err_vec(first0)
    );

    gate_stim_checker #(
        .N_IN(3), .HOLD_CYCLES(2), .EXPECTED(8'h00), .ERR_W(2)
    ) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start1), .dut_y(y_s), .stim(stim_s),
        .busy(busy_s), .done(done_s), .pass(pass_s), .err_count(err_s), .first_err_vec(first_s)
    );

    gate_stim_checker #(
        .N_IN(3), .HOLD_CYCLES(2), .EXPECTED(8'hFF), .ERR_W(2)
    ) u_x (
        .clk(clk), .rst_n(rst_n), .start(start1), .dut_y(y_x), .stim(stim_x),
        .busy(busy_x), .done(done_x), .pass(pass_x), .err_count(err_x), .first_err_vec(first_x)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One-cycle start pulse; returns on the falling edge after the accepting edge.
    task automatic applyStimulus(input bit boundary);
        @(negedge clk);
        if (boundary) start1 = 1'b1;
        else          start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic runToDone(input int inject_at, output int n);
        n = 0;
        while (!done0 && n < 200) begin
            start0 = (n == inject_at);
            if (n % 10 == 5 && n < 40) stim_seen[n/10] = stim0;
            @(negedge clk);
            n++;
        end
        start0 = 1'b0;
    endtask

    task automatic checkRun(input string tag, input int n, input logic [7:0] exp_err,
                            input logic [1:0] exp_first, input logic exp_pass);
        checkOutput({tag, "_latency"}, n, 40);
        checkOutput({tag, "_done"}, done0, 1'b1);
        checkOutput({tag, "_busy"}, busy0, 1'b0);
        checkOutput({tag, "_err"}, err0, exp_err);
        checkOutput({tag, "_first"}, first0, exp_first);
        checkOutput({tag, "_pass"}, pass0, exp_pass);
    endtask

    initial begin
        int n;
        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        mode   = 0;
        repeat (3) @(negedge clk);
        checkOutput("rst_stim", stim0, 0);
        checkOutput("rst_busy", busy0, 0);
        checkOutput("rst_done", done0, 0);
        checkOutput("rst_pass", pass0, 0);
        checkOutput("rst_err", err0, 0);
        checkOutput("rst_first", first0, 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_busy", busy0, 0);

        $display("[TB] correct AND gate");
        applyStimulus(1'b0);
        checkOutput("and_busy_start", busy0, 1);
        checkOutput("and_stim_start", stim0, 0);
        runToDone(-1, n);
        for (int i = 0; i < 4; i++) checkOutput($sformatf("and_stim_step%0d", i), stim_seen[i], i);
        checkRun("and", n, 8'd0, 2'd0, 1'b1);
        checkOutput("and_stim_final", stim0, 3);
        repeat (5) @(negedge clk);
        checkOutput("and_done_hold", done0, 1);
        checkOutput("and_stim_hold", stim0, 3);

        $display("[TB] stuck-at-0 gate, started from DONE");
        mode = 1;
        applyStimulus(1'b0);
        checkOutput("sa0_busy_start", busy0, 1);
        checkOutput("sa0_done_clear", done0, 0);
        runToDone(-1, n);
        checkRun("sa0", n, 8'd1, 2'd3, 1'b0);

        $display("[TB] NAND gate against AND table");
        mode = 2;
        applyStimulus(1'b0);
        checkOutput("nand_err_clear", err0, 0);
        runToDone(-1, n);
        checkRun("nand", n, 8'd4, 2'd0, 1'b0);

        $display("[TB] correct gate, extra start mid-run");
        mode = 0;
        applyStimulus(1'b0);
        checkOutput("rerun_err_clear", err0, 0);
        runToDone(15, n);
        checkRun("rerun", n, 8'd0, 2'd0, 1'b1);

        $display("[TB] asynchronous reset mid-run");
        applyStimulus(1'b0);
        repeat (25) @(negedge clk);
        checkOutput("abort_stim_before", stim0, 2);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_stim", stim0, 0);
        checkOutput("abort_busy", busy0, 0);
        checkOutput("abort_done", done0, 0);
        checkOutput("abort_err", err0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0);
        checkOutput("post_abort_stim", stim0, 0);
        runToDone(-1, n);
        checkRun("post_abort", n, 8'd0, 2'd0, 1'b1);

        $display("[TB] boundary configuration");
        applyStimulus(1'b1);
        n = 0;
        while (!done_s && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("sat_latency", n, 16);
        checkOutput("sat_done", done_s, 1);
        checkOutput("sat_err", err_s, 3);
        checkOutput("sat_first", first_s, 0);
        checkOutput("sat_pass", pass_s, 0);
        checkOutput("sat_stim_final", stim_s, 7);
        checkOutput("x_done", done_x, 1);
        checkOutput("x_err", err_x, 3);
        checkOutput("x_first", first_x, 0);
        checkOutput("x_pass", pass_x, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
